fv_pingpong_bank_array: RTL
===========================

Name: fv_pingpong_bank_array

Overview:
Parametrised successor to the fixed 4-bank big-FV buffer. It holds NUM_BANKS independent banks, each with two DEPTH-word buffers (ping/pong) in internal behavioural SRAM with 1-cycle read latency.
- Active (ping) buffer streams FV words to the small-FV stage.
- Shadow (pong) buffer serves Edge-PE read/write requests.
- A handshaked swap exchanges the two roles between update iterations.

Parameters:
NUM_BANKS, 4, number of banks / request channels
DATA_W, 16, FV word width
DEPTH, 64, words per buffer; AW = $clog2(DEPTH)
TAG_W, 2, Edge-PE tag width
FVN_W, 7, width of fv_num (must cover the value DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_BANKS  per-bank request strobe
req_wr  in  NUM_BANKS  1=write, 0=read
req_addr  in  NUM_BANKS*AW  word address, bank b at [b*AW +: AW]
req_data  in  NUM_BANKS*DATA_W  write data
req_tag  in  NUM_BANKS*TAG_W  PE tag returned with read data
req_ready  out  NUM_BANKS  request accept
rd_valid  out  NUM_BANKS  read response valid
rd_tag  out  NUM_BANKS*TAG_W  echoed tag
rd_data  out  NUM_BANKS*DATA_W  read data
fv_num  in  FVN_W  words per bank to stream
stream_begin  in  1  start stream on all banks
swap  in  1  request ping/pong role exchange
strm_valid  out  NUM_BANKS  stream word valid
strm_sos  out  NUM_BANKS  first word of stream
strm_eos  out  NUM_BANKS  last word of stream
strm_addr  out  NUM_BANKS*AW  word index of strm_data
strm_data  out  NUM_BANKS*DATA_W  stream word
active_buf  out  1  buffer index currently streaming
available  out  1  all banks idle, swap/stream may be issued

Behaviour:
- Reset: every output is 0, all bank FSMs go to IDLE, active_buf=0. Memory contents are not cleared. Reset asserted mid-stream aborts the stream immediately; no eos is emitted.
- Per-bank FSM states are IDLE, STREAM and LAST.
  - IDLE->STREAM on stream_begin && available && fv_num!=0. The word count latches min(fv_num, DEPTH).
  - STREAM issues reads of active buffer addresses 0..N-1, one per cycle. When address N-1 is issued -> LAST.
  - LAST waits one cycle for the final data, then -> IDLE.
  - N=1 goes directly IDLE->LAST.
- Stream output timing: strm_valid asserts the cycle after each address issue. strm_sos accompanies addr 0, strm_eos accompanies addr N-1; both assert together when N=1. The stream cannot stall.
- stream_begin is ignored when available=0 or fv_num=0.
- available = all banks in IDLE. It is registered and updates the cycle after the FSM change.
- swap: when swap && available, active_buf toggles on the next edge. A swap with available=0 is dropped, not queued.
- swap and stream_begin in the same cycle: the swap takes effect first, and the stream reads the new active buffer.
- Requests: req_ready[b]=1 except in the cycle where a swap is accepted (req_ready=0 for all banks). Accepted requests always target buffer ~active_buf.
  - A write commits at the edge.
  - A read returns rd_valid/rd_tag/rd_data exactly 1 cycle later.
  - Back-to-back reads give 1 response per cycle.
  - req_valid while req_ready=0 is discarded.
- Stream and request traffic use separate buffers, so there is no port conflict. Each buffer is a 1-port SRAM with one access per cycle.
- Addresses are AW bits; req_addr >= DEPTH is not possible when DEPTH is a power of 2. Otherwise the access is ignored, and a read returns data 0 with rd_valid still asserted.

Optional Feature:
Macro FV_PP_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit computed on write.
  - Two extra outputs, rd_perr[NUM_BANKS] and strm_perr[NUM_BANKS], assert alongside rd_valid/strm_valid when the parity check on the read word fails.
  - A parity-corruption hook is available to the bench through a hierarchical force on the stored parity bit.
- Undefined: no parity storage and the two ports are absent; all other behaviour is identical.

Test Plan:
- Reset, then write bank0 addr 5 = 0x1234 (tag 2) on buffer 1, then read addr 5 -> rd_valid[0] one cycle later with rd_tag=2, rd_data=0x1234.
- Fill buffer 1 of every bank with addr+b*0x100, swap -> active_buf=1. Then stream_begin with fv_num=4 -> each bank emits 4 words 0..3 (bank2: 0x200..0x203), sos on word 0, eos on word 3, available=0 until 2 cycles after eos.
- fv_num=1 -> single strm_valid with sos=eos=1. fv_num=0 or fv_num=100 (DEPTH 64) -> no stream, or exactly 64 words, respectively.
- swap and stream_begin in the same cycle while mid-stream -> both ignored, active_buf unchanged. Retry when available=1 -> both accepted, and the stream reads the new buffer.
- Assert reset during word 2 of an 8-word stream -> the next cycle shows all outputs 0, no eos, available=1 after release. Previously written data is still readable.
- With FV_PP_PARITY_EN, corrupt the parity of bank3 addr 7 -> strm_perr[3]=1 only on the strm_addr=7 beat.

Source files
------------

// File: rtl/fv_pingpong_bank_array.sv
// fv_pingpong_bank_array: NUM_BANKS ping/pong FV buffers, active buffer streams while shadow serves Edge-PE requests; FV_PP_PARITY_EN adds per-word even parity with rd_perr/strm_perr
module fv_pingpong_bank_array #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  parameter int TAG_W = 2,
  parameter int FVN_W = 7,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BANKS-1:0]        req_valid,
  input  logic [NUM_BANKS-1:0]        req_wr,
  input  logic [NUM_BANKS*AW-1:0]     req_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] req_data,
  input  logic [NUM_BANKS*TAG_W-1:0]  req_tag,
  output logic [NUM_BANKS-1:0]        req_ready,
  output logic [NUM_BANKS-1:0]        rd_valid,
  output logic [NUM_BANKS*TAG_W-1:0]  rd_tag,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data,
  input  logic [FVN_W-1:0]            fv_num,
  input  logic                        stream_begin,
  input  logic                        swap,
  output logic [NUM_BANKS-1:0]        strm_valid,
  output logic [NUM_BANKS-1:0]        strm_sos,
  output logic [NUM_BANKS-1:0]        strm_eos,
  output logic [NUM_BANKS*AW-1:0]     strm_addr,
  output logic [NUM_BANKS*DATA_W-1:0] strm_data,
  output logic                        active_buf,
  output logic                        available
`ifdef FV_PP_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0]        rd_perr,
  output logic [NUM_BANKS-1:0]        strm_perr
`endif
);
`ifdef FV_PP_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [AW:0] N_ONE = 1;
  typedef enum logic [1:0] {IDLE, STREAM, LAST} state_t;
  logic [MW-1:0] mem [NUM_BANKS][2][DEPTH];
  state_t state_q [NUM_BANKS];
  state_t state_d [NUM_BANKS];
  logic [AW:0] n_q [NUM_BANKS];
  logic [AW:0] n_d [NUM_BANKS];
  logic [AW:0] cnt_q [NUM_BANKS];
  logic [AW:0] cnt_d [NUM_BANKS];
  logic [AW-1:0] iaddr [NUM_BANKS];
  logic [AW-1:0] raddr [NUM_BANKS];
  logic [MW-1:0] rword [NUM_BANKS];
  logic [MW-1:0] sword [NUM_BANKS];
  logic [MW-1:0] wword [NUM_BANKS];
  logic [NUM_BANKS-1:0] issue, last, idle, acc, in_rng;
  logic swap_acc, start, rbuf;
  logic [AW:0] n_new;
  assign swap_acc = swap && available;
  assign start = stream_begin && available && fv_num != '0;
  assign rbuf = active_buf ^ swap_acc;
  assign n_new = fv_num > FVN_W'(DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(fv_num);
  assign req_ready = {NUM_BANKS{!reset && !swap_acc}};
  assign acc = req_valid & req_ready;
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b] = state_q[b];
      n_d[b] = n_q[b];
      cnt_d[b] = cnt_q[b];
      issue[b] = 1'b0;
      iaddr[b] = cnt_q[b][AW-1:0];
      idle[b] = state_q[b] == IDLE;
      case (state_q[b])
        IDLE: if (start) begin
          issue[b] = 1'b1;
          iaddr[b] = '0;
          n_d[b] = n_new;
          cnt_d[b] = N_ONE;
          state_d[b] = n_new == N_ONE ? LAST : STREAM;
        end
        STREAM: begin
          issue[b] = 1'b1;
          cnt_d[b] = cnt_q[b] + N_ONE;
          state_d[b] = cnt_q[b] == n_q[b] - N_ONE ? LAST : STREAM;
        end
        LAST: state_d[b] = IDLE;
        default: state_d[b] = IDLE;
      endcase
      last[b] = issue[b] && (AW+1)'(iaddr[b]) == n_d[b] - N_ONE;
      raddr[b] = req_addr[b*AW +: AW];
      in_rng[b] = (AW+1)'(raddr[b]) < (AW+1)'(DEPTH);
      rword[b] = in_rng[b] ? mem[b][!active_buf][raddr[b]] : '0;
      sword[b] = mem[b][rbuf][iaddr[b]];
`ifdef FV_PP_PARITY_EN
      wword[b] = {^req_data[b*DATA_W +: DATA_W], req_data[b*DATA_W +: DATA_W]};
`else
      wword[b] = req_data[b*DATA_W +: DATA_W];
`endif
    end
  end
  always_ff @(posedge clk)
    for (int b = 0; b < NUM_BANKS; b++)
      if (acc[b] && req_wr[b] && in_rng[b]) mem[b][!active_buf][raddr[b]] <= wword[b];
  always_ff @(posedge clk) begin
    if (reset) begin
      active_buf <= 1'b0;
      available <= 1'b0;
      rd_valid <= '0;
      rd_tag <= '0;
      rd_data <= '0;
      strm_valid <= '0;
      strm_sos <= '0;
      strm_eos <= '0;
      strm_addr <= '0;
      strm_data <= '0;
`ifdef FV_PP_PARITY_EN
      rd_perr <= '0;
      strm_perr <= '0;
`endif
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= IDLE;
        n_q[b] <= '0;
        cnt_q[b] <= '0;
      end
    end else begin
      active_buf <= active_buf ^ swap_acc;
      available <= &idle && !start;
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
        n_q[b] <= n_d[b];
        cnt_q[b] <= cnt_d[b];
        rd_valid[b] <= acc[b] && !req_wr[b];
        rd_tag[b*TAG_W +: TAG_W] <= acc[b] && !req_wr[b] ? req_tag[b*TAG_W +: TAG_W] : '0;
        rd_data[b*DATA_W +: DATA_W] <= acc[b] && !req_wr[b] ? rword[b][DATA_W-1:0] : '0;
        strm_valid[b] <= issue[b];
        strm_sos[b] <= issue[b] && iaddr[b] == '0;
        strm_eos[b] <= last[b];
        strm_addr[b*AW +: AW] <= issue[b] ? iaddr[b] : '0;
        strm_data[b*DATA_W +: DATA_W] <= issue[b] ? sword[b][DATA_W-1:0] : '0;
`ifdef FV_PP_PARITY_EN
        rd_perr[b] <= acc[b] && !req_wr[b] && ^rword[b];
        strm_perr[b] <= issue[b] && ^sword[b];
`endif
      end
    end
  end
endmodule
